// File: rtl/log_mul_pkg.sv
// Shared constants and types for the log-scale multiplier and its LUT loader.
// Module parameters default to these values so every block agrees on the table geometry.
package log_mul_pkg;

    localparam int FLOAT_LEN      = 16;
    localparam int EXP_LEN        = 5;
    localparam int MANT_LEN       = 10;
    localparam int LUT_SIZE       = 128;
    localparam int TIMEOUT_CYCLES = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } lut_ld_state_e;

endpackage

// File: rtl/log_lut_loader_if.sv
// Table-source fetch bus plus multiplier LUT write bus, as seen by the loader.
// The master side is the loader; the slave side is the source/multiplier pair.
interface log_lut_loader_if
    import log_mul_pkg::*;
#(
    parameter int FLOAT_LEN = log_mul_pkg::FLOAT_LEN,
    parameter int MANT_LEN  = log_mul_pkg::MANT_LEN,
    parameter int LUT_SIZE  = log_mul_pkg::LUT_SIZE
);

    localparam int ADDR_W = $clog2(LUT_SIZE);

    logic                 src_req;
    logic [ADDR_W-1:0]    src_addr;
    logic                 src_valid;
    logic [MANT_LEN-1:0]  src_log2_data;
    logic [FLOAT_LEN-1:0] src_exp2_data;

    logic                 lut_wr_en;
    logic [MANT_LEN-1:0]  log2_lut_data_in;
    logic [FLOAT_LEN-1:0] exp2_lut_data_in;

    modport master (
        output src_req,
        output src_addr,
        input  src_valid,
        input  src_log2_data,
        input  src_exp2_data,
        output lut_wr_en,
        output log2_lut_data_in,
        output exp2_lut_data_in
    );

    modport slave (
        input  src_req,
        input  src_addr,
        output src_valid,
        output src_log2_data,
        output src_exp2_data,
        input  lut_wr_en,
        input  log2_lut_data_in,
        input  exp2_lut_data_in
    );

endinterface

// File: rtl/log_lut_loader.sv
// Fetches LUT_SIZE log2/exp2 entries from a variable-latency source and streams them,
// in address order, to the multiplier LUT exactly once per reset.
module log_lut_loader
    import log_mul_pkg::*;
#(
    parameter int FLOAT_LEN      = log_mul_pkg::FLOAT_LEN,
    parameter int MANT_LEN       = log_mul_pkg::MANT_LEN,
    parameter int LUT_SIZE       = log_mul_pkg::LUT_SIZE,
    parameter int TIMEOUT_CYCLES = log_mul_pkg::TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    log_lut_loader_if.master           lut_bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(LUT_SIZE):0]  entries_written
);

    localparam int ADDR_W  = $clog2(LUT_SIZE);
    localparam int CNT_W   = ADDR_W + 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(LUT_SIZE - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(LUT_SIZE);

    lut_ld_state_e      state;
    lut_ld_state_e      state_next;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  idx_next;
    logic [TIMER_W-1:0] timer;

    // DONE and ERR have no exits: the multiplier write pointer only rewinds on rst_n.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                    idx_next   = '0;
                end
            end
            REQ: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (lut_bus.src_valid) begin
                    state_next = WRITE;
                end else if (timer == TIMER_LAST) begin
                    state_next = ERR;
                end
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    state_next = REQ;
                    idx_next   = idx + ADDR_W'(1);
                end
            end
            DONE, ERR: begin
                state_next = state;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            timer <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (state == REQ) begin
                timer <= '0;
            end else if (state == WAIT && !lut_bus.src_valid) begin
                timer <= timer + TIMER_W'(1);
            end
        end
    end

    // Outputs are decoded from the next state so every one of them comes straight off a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_bus.src_req          <= 1'b0;
            lut_bus.src_addr         <= '0;
            lut_bus.lut_wr_en        <= 1'b0;
            lut_bus.log2_lut_data_in <= '0;
            lut_bus.exp2_lut_data_in <= '0;
            busy                     <= 1'b0;
            done                     <= 1'b0;
            err                      <= 1'b0;
            entries_written          <= '0;
        end else begin
            lut_bus.src_req   <= (state_next == REQ);
            lut_bus.lut_wr_en <= (state_next == WRITE);
            busy              <= (state_next == REQ) || (state_next == WAIT) ||
                                 (state_next == WRITE);
            done              <= (state_next == DONE);
            err               <= (state_next == ERR);

            if (state_next == REQ) begin
                lut_bus.src_addr <= idx_next;
            end

            if (state == WAIT && lut_bus.src_valid) begin
                lut_bus.log2_lut_data_in <= lut_bus.src_log2_data;
                lut_bus.exp2_lut_data_in <= lut_bus.src_exp2_data;
                if (entries_written != CNT_FULL) begin
                    entries_written <= entries_written + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_log_lut_loader.sv
// Directed bench for log_lut_loader: a latency-configurable table source drives the fetch side
// and a scoreboard checks every LUT write against address-derived expected entries.
module tb_log_lut_loader;

    localparam int FLOAT_LEN      = 16;
    localparam int MANT_LEN       = 10;
    localparam int LUT_SIZE       = 128;
    localparam int TIMEOUT_CYCLES = 256;
    localparam int CNT_W          = $clog2(LUT_SIZE) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] entries_written;

    int pass_count = 0;
    int check_count = 0;
    int model_writes = 0;
    int src_mode = 0;
    int withhold_addr = -1;

    log_lut_loader_if #(.FLOAT_LEN(FLOAT_LEN), .MANT_LEN(MANT_LEN), .LUT_SIZE(LUT_SIZE)) bus ();

    log_lut_loader #(
        .FLOAT_LEN(FLOAT_LEN),
        .MANT_LEN(MANT_LEN),
        .LUT_SIZE(LUT_SIZE),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .lut_bus(bus.master),
        .busy(busy),
        .done(done),
        .err(err),
        .entries_written(entries_written)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_log2(input int a);
        return 32'(a * 7) & 32'h3FF;
    endfunction

    function automatic logic [31:0] exp_exp2(input int a);
        return 32'h3C00 | 32'(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyReset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic waitForFlag(input string name, input int max_cycles, input bit use_err);
        int n;
        n = 0;
        while (((use_err ? err : done) !== 1'b1) && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, use_err ? err : done, 1);
    endtask

    // Table source: answers each request after L cycles; mode 2 adds junk strobes around it.
    initial begin : source
        int a;
        int lat;
        bus.src_valid = 1'b0;
        bus.src_log2_data = '0;
        bus.src_exp2_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.src_req) begin
                a = int'(bus.src_addr);
                if (a == withhold_addr) continue;
                lat = (src_mode == 1) ? int'($urandom_range(1, 20)) : ((src_mode == 2) ? 2 : 1);
                if (src_mode == 2) begin
                    bus.src_valid = 1'b1;
                    bus.src_log2_data = 10'h3FF;
                    bus.src_exp2_data = 16'hDEAD;
                end
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk); #1;
                    bus.src_valid = 1'b0;
                end
                bus.src_valid = 1'b1;
                bus.src_log2_data = MANT_LEN'(exp_log2(a));
                bus.src_exp2_data = FLOAT_LEN'(exp_exp2(a));
                @(posedge clk); #1;
                bus.src_valid = 1'b0;
                if (src_mode == 2) begin
                    bus.src_valid = 1'b1;
                    bus.src_log2_data = 10'h2AA;
                    bus.src_exp2_data = 16'hBEEF;
                    @(posedge clk); #1;
                    bus.src_valid = 1'b0;
                end
            end
        end
    end

    initial begin : compare
        bit prev_req;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_writes = 0;
                prev_req = 1'b0;
                continue;
            end
            if (bus.src_req) begin
                checkOutput("src_addr", 32'(bus.src_addr), 32'(model_writes));
                checkOutput("src_req_one_cycle", 32'(prev_req), 0);
            end
            prev_req = bus.src_req;
            if (bus.lut_wr_en) begin
                checkOutput("write_limit", 32'(model_writes < LUT_SIZE), 1);
                checkOutput("log2_data", 32'(bus.log2_lut_data_in), exp_log2(model_writes));
                checkOutput("exp2_data", 32'(bus.exp2_lut_data_in), exp_exp2(model_writes));
                model_writes++;
                checkOutput("entries_written", 32'(entries_written), 32'(model_writes));
                checkOutput("busy_during_write", 32'(busy), 1);
            end
            if (done || err) begin
                checkOutput("busy_terminal", 32'(busy), 0);
                checkOutput("done_err_exclusive", 32'(done && err), 0);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_entries", 32'(entries_written), 0);
        checkOutput("reset_src_req", 32'(bus.src_req), 0);
        checkOutput("reset_wr_en", 32'(bus.lut_wr_en), 0);
        rst_n = 1'b1;

        $display("[TB] test 1: fixed latency 1, done timing");
        src_mode = 0;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t1_first_wr_en", 32'(bus.lut_wr_en), 1);
        checkOutput("t1_first_log2", 32'(bus.log2_lut_data_in), 32'h000);
        checkOutput("t1_first_exp2", 32'(bus.exp2_lut_data_in), 32'h3C00);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("t1_addr3_log2", 32'(bus.log2_lut_data_in), 32'h015);
        checkOutput("t1_addr3_exp2", 32'(bus.exp2_lut_data_in), 32'h3C03);
        repeat (372) @(posedge clk);
        #1;
        checkOutput("t1_last_log2", 32'(bus.log2_lut_data_in), 32'h379);
        checkOutput("t1_last_exp2", 32'(bus.exp2_lut_data_in), 32'h3C7F);
        checkOutput("t1_done_early", 32'(done), 0);
        @(posedge clk); #1;
        checkOutput("t1_done_edge384", 32'(done), 1);
        checkOutput("t1_entries", 32'(entries_written), 128);

        $display("[TB] test 4a: start after done");
        applyStimulus();
        repeat (30) @(posedge clk);
        #1;
        checkOutput("t4_entries_after_done", 32'(entries_written), 128);
        checkOutput("t4_model_writes", 32'(model_writes), 128);
        checkOutput("t4_still_done", 32'(done), 1);

        $display("[TB] test 2: random latency, start while busy");
        applyReset();
        src_mode = 1;
        applyStimulus();
        repeat (100) @(posedge clk);
        #1;
        checkOutput("t2_busy", 32'(busy), 1);
        applyStimulus();
        waitForFlag("t2_done", 4000, 1'b0);
        checkOutput("t2_err", 32'(err), 0);
        checkOutput("t2_entries", 32'(entries_written), 128);
        checkOutput("t2_model_writes", 32'(model_writes), 128);

        $display("[TB] test 3: source timeout on addr 5");
        applyReset();
        src_mode = 0;
        withhold_addr = 5;
        applyStimulus();
        repeat (271) @(posedge clk);
        #1;
        checkOutput("t3_err_early", 32'(err), 0);
        checkOutput("t3_busy_waiting", 32'(busy), 1);
        @(posedge clk); #1;
        checkOutput("t3_err_edge272", 32'(err), 1);
        checkOutput("t3_busy", 32'(busy), 0);
        checkOutput("t3_entries", 32'(entries_written), 5);
        checkOutput("t3_done", 32'(done), 0);
        applyStimulus();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t3_model_writes", 32'(model_writes), 5);
        checkOutput("t3_err_sticky", 32'(err), 1);
        withhold_addr = -1;

        $display("[TB] test 5: reset mid-load");
        applyReset();
        applyStimulus();
        for (int n = 0; n < 1000 && model_writes < 50; n++) @(negedge clk);
        #2;
        checkOutput("t5_reached_50", 32'(model_writes), 50);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_busy", 32'(busy), 0);
        checkOutput("t5_async_entries", 32'(entries_written), 0);
        checkOutput("t5_async_src_req", 32'(bus.src_req), 0);
        checkOutput("t5_async_wr_en", 32'(bus.lut_wr_en), 0);
        checkOutput("t5_async_log2", 32'(bus.log2_lut_data_in), 0);
        checkOutput("t5_async_exp2", 32'(bus.exp2_lut_data_in), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus();
        waitForFlag("t5_done", 2000, 1'b0);
        checkOutput("t5_entries", 32'(entries_written), 128);
        checkOutput("t5_model_writes", 32'(model_writes), 128);

        $display("[TB] test 6: stray src_valid ignored");
        applyReset();
        bus.src_valid = 1'b1;
        bus.src_log2_data = 10'h155;
        bus.src_exp2_data = 16'h1234;
        @(posedge clk); #1;
        bus.src_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("t6_idle_no_write", 32'(entries_written), 0);
        checkOutput("t6_idle_busy", 32'(busy), 0);
        src_mode = 2;
        applyStimulus();
        waitForFlag("t6_done", 3000, 1'b0);
        checkOutput("t6_entries", 32'(entries_written), 128);
        checkOutput("t6_model_writes", 32'(model_writes), 128);
        checkOutput("t6_err", 32'(err), 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
